// File: rtl/perceptron_predictor_core.sv
// Perceptron branch-direction predictor.
// 2-stage predict pipe, handshaked trainer, GHR repair.
module perceptron_predictor_core #(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 6,
  parameter int HIST_LEN = 16,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = 44,
  localparam int SUM_W   = WEIGHT_W + $clog2(HIST_LEN + 2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_req_valid,
  input  logic [PC_W-1:0]     pred_pc,
  output logic                pred_resp_valid,
  output logic                pred_taken,
  output logic [SUM_W-1:0]    pred_sum,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  input  logic [SUM_W-1:0]    upd_sum,
  input  logic [HIST_LEN-1:0] upd_ghr
);

  localparam int NUM_ENTRIES = 2 ** IDX_W;
  localparam int ROW_N = HIST_LEN + 1;

  localparam logic [WEIGHT_W-1:0] W_MAX =
    {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN =
    {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef logic [ROW_N-1:0][WEIGHT_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } upd_state_e;

  typedef struct packed {
    logic                taken;
    logic                mis;
    logic [SUM_W-1:0]    sum;
    logic [HIST_LEN-1:0] ghr;
    logic [IDX_W-1:0]    idx;
  } upd_t;

  function automatic logic [WEIGHT_W-1:0] sat_step(
    input logic [WEIGHT_W-1:0] w,
    input logic                up
  );
    logic [WEIGHT_W-1:0] r;
    r = w;
    if (up && (w != W_MAX)) r = w + WEIGHT_W'(1);
    if (!up && (w != W_MIN)) r = w - WEIGHT_W'(1);
    return r;
  endfunction

  row_t tbl [NUM_ENTRIES];

  logic [HIST_LEN-1:0] ghr;
  logic                s1_valid;
  row_t                s1_row;
  logic [HIST_LEN-1:0] s1_ghr;

  upd_state_e state_q, state_d;
  logic       live_q;
  upd_t       u_q;
  row_t       u_row;

  logic [IDX_W-1:0]        pred_idx;
  logic [IDX_W-1:0]        upd_idx;
  logic                    upd_fire;
  logic                    repair;
  logic signed [SUM_W-1:0] sum_c;
  logic [SUM_W:0]          sx;
  logic [SUM_W:0]          mag;
  logic                    train;
  row_t                    trn_row;
  logic                    unused_ok;

  assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr);
  assign upd_idx  = upd_pc[IDX_W+1:2] ^ IDX_W'(upd_ghr);

  assign upd_ready = live_q & (state_q == IDLE);
  assign upd_fire  = upd_valid & upd_ready;
  assign repair    = upd_fire & upd_mispredict;

  assign unused_ok = &{1'b0,
    pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
    upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

  // Dot product of the latched row with +/-1 history.
  always_comb begin
    sum_c = SUM_W'($signed(s1_row[0]));
    for (int i = 0; i < HIST_LEN; i++) begin
      if (s1_ghr[i])
        sum_c = sum_c + SUM_W'($signed(s1_row[i+1]));
      else
        sum_c = sum_c - SUM_W'($signed(s1_row[i+1]));
    end
  end

  // Training decision and saturating weight step.
  always_comb begin
    sx      = {u_q.sum[SUM_W-1], u_q.sum};
    mag     = sx[SUM_W] ? -sx : sx;
    train   = u_q.mis | (mag <= (SUM_W+1)'(THETA));
    trn_row = u_row;
    trn_row[0] = sat_step(u_row[0], u_q.taken);
    for (int i = 0; i < HIST_LEN; i++) begin
      trn_row[i+1] = sat_step(u_row[i+1],
                              u_q.taken == u_q.ghr[i]);
    end
  end

  // Update FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (upd_fire) state_d = CALC;
      CALC:    state_d = train ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Update FSM state and out-of-reset flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Latch the resolved branch, then hold the trained row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_q   <= '0;
      u_row <= '0;
    end else if (upd_fire) begin
      u_q.taken <= upd_taken;
      u_q.mis   <= upd_mispredict;
      u_q.sum   <= upd_sum;
      u_q.ghr   <= upd_ghr;
      u_q.idx   <= upd_idx;
      u_row     <= tbl[upd_idx];
    end else if (state_q == CALC && train) begin
      u_row <= trn_row;
    end
  end

  // Weight table; written only from WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NUM_ENTRIES; e++) tbl[e] <= '0;
    end else if (state_q == WRITE) begin
      tbl[u_q.idx] <= u_row;
    end
  end

  // Predict pipe, speculative history and repair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid        <= 1'b0;
      s1_row          <= '0;
      s1_ghr          <= '0;
      ghr             <= '0;
      pred_resp_valid <= 1'b0;
      pred_taken      <= 1'b0;
      pred_sum        <= '0;
      pred_ghr        <= '0;
    end else begin
      s1_valid <= pred_req_valid & ~repair;
      if (pred_req_valid) begin
        s1_row <= tbl[pred_idx];
        s1_ghr <= ghr;
      end
      pred_resp_valid <= s1_valid & ~repair;
      if (s1_valid & ~repair) begin
        pred_sum   <= sum_c;
        pred_taken <= ~sum_c[SUM_W-1];
        pred_ghr   <= s1_ghr;
      end
      if (repair)
        ghr <= {upd_ghr[HIST_LEN-2:0], upd_taken};
      else if (s1_valid)
        ghr <= {ghr[HIST_LEN-2:0], ~sum_c[SUM_W-1]};
    end
  end

endmodule
